// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between the instruction-fetch
//               and data-access masters. One transaction at a time: capture
//               the winning request, drive it to memory, pass the reply back.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  // fetch requester (read channels used; write channel is always refused)
  input  logic                i_imem_r_req_valid,
  output logic                o_imem_r_req_ready,
  input  logic [ADDR_W-1:0]   i_imem_raddr,
  output logic                o_imem_r_rep_valid,
  input  logic                i_imem_r_rep_ready,
  output logic [DATA_W-1:0]   o_imem_rdata,
  input  logic                i_imem_w_req_valid,
  output logic                o_imem_w_req_ready,
  input  logic [ADDR_W-1:0]   i_imem_waddr,
  input  logic [DATA_W-1:0]   i_imem_wdata,
  input  logic [DATA_W/8-1:0] i_imem_wmask,
  output logic                o_imem_w_rep_valid,
  input  logic                i_imem_w_rep_ready,
  // data requester
  input  logic                i_dmem_r_req_valid,
  output logic                o_dmem_r_req_ready,
  input  logic [ADDR_W-1:0]   i_dmem_raddr,
  output logic                o_dmem_r_rep_valid,
  input  logic                i_dmem_r_rep_ready,
  output logic [DATA_W-1:0]   o_dmem_rdata,
  input  logic                i_dmem_w_req_valid,
  output logic                o_dmem_w_req_ready,
  input  logic [ADDR_W-1:0]   i_dmem_waddr,
  input  logic [DATA_W-1:0]   i_dmem_wdata,
  input  logic [DATA_W/8-1:0] i_dmem_wmask,
  output logic                o_dmem_w_rep_valid,
  input  logic                i_dmem_w_rep_ready,
  // shared memory port
  output logic                o_mem_r_req_valid,
  input  logic                i_mem_r_req_ready,
  output logic [ADDR_W-1:0]   o_mem_raddr,
  input  logic                i_mem_r_rep_valid,
  output logic                o_mem_r_rep_ready,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_mem_w_req_valid,
  input  logic                i_mem_w_req_ready,
  output logic [ADDR_W-1:0]   o_mem_waddr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wmask,
  input  logic                i_mem_w_rep_valid,
  output logic                o_mem_w_rep_ready,
  // status
  output logic [1:0]          grant,
  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_owner_d;   // 1 = dmem owns the current transaction
  logic                r_last_d;    // 1 = dmem was granted most recently
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;
  logic [1:0]          r_grant;
  logic                r_busy;

  logic w_idle;
  logic w_i_cand;
  logic w_d_cand;
  logic w_pick_d;
  logic w_pick_i;
  logic w_d_wr;
  logic w_d_rd;
  logic w_rrep_ready;
  logic w_unused;

  // Arbitration: round-robin between sides, write beats read inside dmem.
  // Readies are also masked by reset so nothing handshakes while held in reset.
  assign w_idle   = (r_state == S_IDLE) && rst;
  assign w_i_cand = i_imem_r_req_valid;
  assign w_d_cand = i_dmem_r_req_valid | i_dmem_w_req_valid;
  assign w_pick_d = w_d_cand & (~w_i_cand | ~r_last_d);
  assign w_pick_i = w_i_cand & ~w_pick_d;
  assign w_d_wr   = w_pick_d & i_dmem_w_req_valid;
  assign w_d_rd   = w_pick_d & ~i_dmem_w_req_valid;

  assign o_imem_r_req_ready = w_idle & w_pick_i;
  assign o_dmem_w_req_ready = w_idle & w_d_wr;
  assign o_dmem_r_req_ready = w_idle & w_d_rd;

  // Memory request side is driven straight from the hold registers.
  assign o_mem_r_req_valid = (r_state == S_RD_REQ);
  assign o_mem_w_req_valid = (r_state == S_WR_REQ);
  assign o_mem_raddr       = r_addr;
  assign o_mem_waddr       = r_addr;
  assign o_mem_wdata       = r_wdata;
  assign o_mem_wmask       = r_wmask;

  // Reply channels pass through to the owner only while waiting on memory.
  assign w_rrep_ready       = r_owner_d ? i_dmem_r_rep_ready : i_imem_r_rep_ready;
  assign o_mem_r_rep_ready  = (r_state == S_RD_WAIT) & w_rrep_ready;
  assign o_imem_r_rep_valid = (r_state == S_RD_WAIT) & ~r_owner_d & i_mem_r_rep_valid;
  assign o_dmem_r_rep_valid = (r_state == S_RD_WAIT) &  r_owner_d & i_mem_r_rep_valid;
  assign o_mem_w_rep_ready  = (r_state == S_WR_WAIT) & i_dmem_w_rep_ready;
  assign o_dmem_w_rep_valid = (r_state == S_WR_WAIT) & r_owner_d & i_mem_w_rep_valid;
  assign o_imem_rdata       = i_mem_rdata;
  assign o_dmem_rdata       = i_mem_rdata;

  // The fetch side never writes.
  assign o_imem_w_req_ready = 1'b0;
  assign o_imem_w_rep_valid = 1'b0;
  assign w_unused = &{1'b0, i_imem_w_req_valid, i_imem_waddr, i_imem_wdata,
                      i_imem_wmask, i_imem_w_rep_ready};

  assign grant = r_grant;
  assign busy  = r_busy;

  // Transaction FSM with registered grant/busy and request hold registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_owner_d <= 1'b0;
      r_last_d  <= 1'b1;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_grant   <= 2'b00;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_i) begin
            r_addr    <= i_imem_raddr;
            r_owner_d <= 1'b0;
            r_last_d  <= 1'b0;
            r_grant   <= 2'b01;
            r_busy    <= 1'b1;
            r_state   <= S_RD_REQ;
          end else if (w_d_wr) begin
            r_addr    <= i_dmem_waddr;
            r_wdata   <= i_dmem_wdata;
            r_wmask   <= i_dmem_wmask;
            r_owner_d <= 1'b1;
            r_last_d  <= 1'b1;
            r_grant   <= 2'b10;
            r_busy    <= 1'b1;
            r_state   <= S_WR_REQ;
          end else if (w_d_rd) begin
            r_addr    <= i_dmem_raddr;
            r_owner_d <= 1'b1;
            r_last_d  <= 1'b1;
            r_grant   <= 2'b10;
            r_busy    <= 1'b1;
            r_state   <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (i_mem_r_req_ready) r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (i_mem_r_rep_valid && w_rrep_ready) begin
            r_grant <= 2'b00;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WR_REQ: begin
          if (i_mem_w_req_ready) r_state <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (i_mem_w_rep_valid && i_dmem_w_rep_ready) begin
            r_grant <= 2'b00;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter with a
//               small memory responder and auto-dropping requester valids.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        imem_rv, imem_rrdy, imem_rep_v, imem_rep_rdy;
  logic [63:0] imem_raddr, imem_rdata;
  logic        imem_wv, imem_wrdy, imem_wrep_v, imem_wrep_rdy;
  logic [63:0] imem_waddr, imem_wdata;
  logic [7:0]  imem_wmask;
  logic        dmem_rv, dmem_rrdy, dmem_rep_v, dmem_rep_rdy;
  logic [63:0] dmem_raddr, dmem_rdata;
  logic        dmem_wv, dmem_wrdy, dmem_wrep_v, dmem_wrep_rdy;
  logic [63:0] dmem_waddr, dmem_wdata;
  logic [7:0]  dmem_wmask;
  logic        mem_rv, m_rreq_rdy, m_rrep_v, mem_rrep_rdy;
  logic [63:0] mem_raddr, m_rdata;
  logic        mem_wv, m_wreq_rdy, m_wrep_v, mem_wrep_rdy;
  logic [63:0] mem_waddr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic [1:0]  grant;
  logic        busy;

  int          n_checks;
  int          n_errors;
  int          n_irep;
  int          log_n;
  logic        log_w [16];
  logic [63:0] log_a [16];

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .i_imem_r_req_valid(imem_rv), .o_imem_r_req_ready(imem_rrdy),
    .i_imem_raddr(imem_raddr), .o_imem_r_rep_valid(imem_rep_v),
    .i_imem_r_rep_ready(imem_rep_rdy), .o_imem_rdata(imem_rdata),
    .i_imem_w_req_valid(imem_wv), .o_imem_w_req_ready(imem_wrdy),
    .i_imem_waddr(imem_waddr), .i_imem_wdata(imem_wdata), .i_imem_wmask(imem_wmask),
    .o_imem_w_rep_valid(imem_wrep_v), .i_imem_w_rep_ready(imem_wrep_rdy),
    .i_dmem_r_req_valid(dmem_rv), .o_dmem_r_req_ready(dmem_rrdy),
    .i_dmem_raddr(dmem_raddr), .o_dmem_r_rep_valid(dmem_rep_v),
    .i_dmem_r_rep_ready(dmem_rep_rdy), .o_dmem_rdata(dmem_rdata),
    .i_dmem_w_req_valid(dmem_wv), .o_dmem_w_req_ready(dmem_wrdy),
    .i_dmem_waddr(dmem_waddr), .i_dmem_wdata(dmem_wdata), .i_dmem_wmask(dmem_wmask),
    .o_dmem_w_rep_valid(dmem_wrep_v), .i_dmem_w_rep_ready(dmem_wrep_rdy),
    .o_mem_r_req_valid(mem_rv), .i_mem_r_req_ready(m_rreq_rdy),
    .o_mem_raddr(mem_raddr), .i_mem_r_rep_valid(m_rrep_v),
    .o_mem_r_rep_ready(mem_rrep_rdy), .i_mem_rdata(m_rdata),
    .o_mem_w_req_valid(mem_wv), .i_mem_w_req_ready(m_wreq_rdy),
    .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask),
    .i_mem_w_rep_valid(m_wrep_v), .o_mem_w_rep_ready(mem_wrep_rdy),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Memory contents: one known instruction word, otherwise address + 0x1000.
  function automatic logic [63:0] mem_data(input logic [63:0] a);
    if (a == 64'h40) return 64'h0000_0000_0050_0093;
    return a + 64'h1000;
  endfunction

  task automatic clear_drives();
    imem_rv = 0; imem_raddr = 0; imem_rep_rdy = 1;
    imem_wv = 0; imem_waddr = 0; imem_wdata = 0; imem_wmask = 0; imem_wrep_rdy = 1;
    dmem_rv = 0; dmem_raddr = 0; dmem_rep_rdy = 1;
    dmem_wv = 0; dmem_waddr = 0; dmem_wdata = 0; dmem_wmask = 0; dmem_wrep_rdy = 1;
    m_rreq_rdy = 1; m_rrep_v = 0; m_rdata = 0;
    m_wreq_rdy = 1; m_wrep_v = 0;
  endtask

  // One clock: sample handshakes just before the edge, then update the
  // requester/memory models just after it.
  task automatic tick();
    logic h_i, h_dr, h_dw, h_mr, h_mw, h_mrr, h_mwr, h_irep;
    logic [63:0] a_r, a_w;
    #1;
    h_i    = imem_rv & imem_rrdy;
    h_dr   = dmem_rv & dmem_rrdy;
    h_dw   = dmem_wv & dmem_wrdy;
    h_mr   = mem_rv & m_rreq_rdy;
    h_mw   = mem_wv & m_wreq_rdy;
    h_mrr  = m_rrep_v & mem_rrep_rdy;
    h_mwr  = m_wrep_v & mem_wrep_rdy;
    h_irep = imem_rep_v & imem_rep_rdy;
    a_r    = mem_raddr;
    a_w    = mem_waddr;
    @(posedge clk);
    #1;
    if (h_i)   imem_rv = 0;
    if (h_dr)  dmem_rv = 0;
    if (h_dw)  dmem_wv = 0;
    if (h_mrr) m_rrep_v = 0;
    if (h_mwr) m_wrep_v = 0;
    if (h_irep) n_irep++;
    if (h_mr && log_n < 16) begin
      log_w[log_n] = 1'b0; log_a[log_n] = a_r; log_n++;
      m_rrep_v = 1; m_rdata = mem_data(a_r);
    end
    if (h_mw && log_n < 16) begin
      log_w[log_n] = 1'b1; log_a[log_n] = a_w; log_n++;
      m_wrep_v = 1;
    end
    #1;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    check_eq("wait_idle", {63'd0, busy}, 64'd0);
  endtask

  task automatic do_reset();
    rst = 0;
    clear_drives();
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    log_n = 0;
    n_irep = 0;
    #1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; n_irep = 0; log_n = 0;
    rst = 0;
    clear_drives();

    // ---- 1: reset holds everything quiet even with valids toggling ----
    imem_rv = 1; dmem_rv = 1; dmem_wv = 1; m_rrep_v = 1; m_wrep_v = 1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check_eq("rst_rdy_vld",
               {54'd0, imem_rrdy, dmem_rrdy, dmem_wrdy, mem_rv, mem_wv,
                imem_rep_v, dmem_rep_v, dmem_wrep_v, mem_rrep_rdy, mem_wrep_rdy}, 64'd0);
      check_eq("rst_grant_busy", {61'd0, grant, busy}, 64'd0);
      m_rrep_v = ~m_rrep_v; m_wrep_v = ~m_wrep_v;
    end
    clear_drives();
    rst = 1;
    tick();
    check_eq("rel_idle", {61'd0, grant, busy}, 64'd0);

    // ---- 2: single fetch, first grant after reset goes to imem ----
    imem_rv = 1; imem_raddr = 64'h40;
    #1;
    check_eq("f_c0_ready", {63'd0, imem_rrdy}, 64'd1);
    tick();
    check_eq("f_c1_grant", {62'd0, grant}, 64'd1);
    check_eq("f_c1_mreq", {63'd0, mem_rv}, 64'd1);
    check_eq("f_c1_raddr", mem_raddr, 64'h40);
    tick();
    check_eq("f_c2_repv", {63'd0, imem_rep_v}, 64'd1);
    check_eq("f_c2_rdata", imem_rdata, 64'h0050_0093);
    check_eq("f_c2_grant", {62'd0, grant}, 64'd1);
    tick();
    check_eq("f_c3_idle", {61'd0, grant, busy}, 64'd0);

    // ---- 3: ties after reset alternate imem then dmem ----
    do_reset();
    imem_rv = 1; imem_raddr = 64'h200;
    dmem_rv = 1; dmem_raddr = 64'h300;
    #1;
    check_eq("tie1_rdy", {62'd0, imem_rrdy, dmem_rrdy}, 64'b10);
    tick();
    imem_rv = 1; imem_raddr = 64'h210;
    wait_idle(20);
    #1;
    check_eq("tie2_rdy", {62'd0, imem_rrdy, dmem_rrdy}, 64'b01);
    tick();
    check_eq("tie2_grant", {62'd0, grant}, 64'b10);
    wait_idle(20);
    tick();
    check_eq("tie3_grant", {62'd0, grant}, 64'b01);
    wait_idle(20);
    check_eq("tie_log_n", log_n, 3);
    check_eq("tie_log0", log_a[0], 64'h200);
    check_eq("tie_log1", log_a[1], 64'h300);
    check_eq("tie_log2", log_a[2], 64'h210);

    // ---- 4: dmem write and read together, write goes first ----
    log_n = 0;
    dmem_wv = 1; dmem_waddr = 64'h100; dmem_wdata = 64'hDEAD; dmem_wmask = 8'h03;
    dmem_rv = 1; dmem_raddr = 64'h108;
    #1;
    check_eq("wr_rdy", {61'd0, dmem_wrdy, dmem_rrdy, imem_rrdy}, 64'b100);
    tick();
    check_eq("wr_mreq", {62'd0, mem_wv, mem_rv}, 64'b10);
    check_eq("wr_waddr", mem_waddr, 64'h100);
    check_eq("wr_wdata", mem_wdata, 64'hDEAD);
    check_eq("wr_wmask", {56'd0, mem_wmask}, 64'h03);
    check_eq("wr_grant", {62'd0, grant}, 64'b10);
    tick();
    check_eq("wr_repv", {62'd0, dmem_wrep_v, imem_wrep_v}, 64'b10);
    wait_idle(20);
    tick();
    tick();
    check_eq("rd_repv", {63'd0, dmem_rep_v}, 64'd1);
    check_eq("rd_rdata", dmem_rdata, 64'h1108);
    wait_idle(20);
    check_eq("wr_log", {62'd0, log_w[0], log_w[1]}, 64'b10);
    check_eq("wr_log_a0", log_a[0], 64'h100);
    check_eq("wr_log_a1", log_a[1], 64'h108);

    // ---- 5: backpressure on memory request then on requester reply ----
    n_irep = 0;
    m_rreq_rdy = 0; imem_rep_rdy = 0;
    imem_rv = 1; imem_raddr = 64'h80;
    tick();
    for (int k = 0; k < 4; k++) begin
      check_eq("bp_req_hold", {62'd0, mem_rv, busy}, 64'b11);
      check_eq("bp_req_addr", mem_raddr, 64'h80);
      tick();
    end
    m_rreq_rdy = 1;
    tick();
    for (int k = 0; k < 3; k++) begin
      check_eq("bp_rep_hold", {61'd0, imem_rep_v, busy, mem_rrep_rdy}, 64'b110);
      check_eq("bp_rep_data", imem_rdata, 64'h1080);
      check_eq("bp_rep_addr", mem_raddr, 64'h80);
      tick();
    end
    imem_rep_rdy = 1;
    tick();
    check_eq("bp_done", {61'd0, grant, busy}, 64'd0);
    check_eq("bp_one_reply", n_irep, 1);

    // ---- 6: async reset in RD_WAIT, then a clean fetch ----
    do_reset();
    imem_rep_rdy = 0;
    imem_rv = 1; imem_raddr = 64'h40;
    tick();
    tick();
    check_eq("ar_in_wait", {63'd0, imem_rep_v}, 64'd1);
    #3;
    rst = 0;
    #1;
    check_eq("ar_gb", {61'd0, grant, busy}, 64'd0);
    check_eq("ar_vld", {61'd0, imem_rep_v, mem_rv, mem_rrep_rdy}, 64'd0);
    clear_drives();
    @(posedge clk); #1;
    rst = 1;
    #1;
    imem_rv = 1; imem_raddr = 64'h40;
    tick();
    tick();
    check_eq("ar_refetch_v", {63'd0, imem_rep_v}, 64'd1);
    check_eq("ar_refetch_d", imem_rdata, 64'h0050_0093);
    wait_idle(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
